// File: rtl/gpio_mul_pkg.sv
// gpio_mul_pkg: shared constants for the GPIO-bus multiply coprocessor.
// Holds register addresses, status encodings and the FSM state type.
package gpio_mul_pkg;

   localparam logic [15:0] ADDR_A1   = 16'h037F;
   localparam logic [15:0] ADDR_A2   = 16'h0388;
   localparam logic [15:0] ADDR_W    = 16'h0390;
   localparam logic [15:0] ADDR_L    = 16'h0398;
   localparam logic [15:0] ADDR_CTRL = 16'h03A0;

   localparam logic [1:0] ST_IDLE = 2'b11;
   localparam logic [1:0] ST_BUSY = 2'b10;
   localparam logic [1:0] ST_OK   = 2'b00;
   localparam logic [1:0] ST_OVF  = 2'b01;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      CNT,
      DONE
   } state_e;

endpackage

// File: rtl/mul_shift_add.sv
// mul_shift_add: iterative shift-add multiplier, one multiplier bit per
// cycle, LSB first. start loads a/b; busy for DATA_W cycles; done marks
// the last active cycle; prod is the full 2*DATA_W product, held after.
module mul_shift_add #(
   parameter int DATA_W = 24
) (
   input  logic                clk,
   input  logic                n_reset,
   input  logic                start,
   input  logic [DATA_W-1:0]   a,
   input  logic [DATA_W-1:0]   b,
   output logic                busy,
   output logic                done,
   output logic [2*DATA_W-1:0] prod
);

   localparam int PW = 2 * DATA_W;
   localparam int CW = $clog2(DATA_W + 1);

   logic [PW-1:0]     mcand_q, mcand_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [DATA_W-1:0] mplier_q, mplier_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              last;

   assign last = (cnt_q == CW'(DATA_W - 1));
   assign busy = busy_q;
   assign done = busy_q & last;
   assign prod = acc_q;

   always_comb begin
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      if (start) begin
         mcand_d  = PW'(a);
         mplier_d = b;
         acc_d    = '0;
         cnt_d    = '0;
         busy_d   = 1'b1;
      end else if (busy_q) begin
         if (mplier_q[0]) acc_d = acc_q + mcand_q;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CW'(1);
         if (last) busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
      end
   end

endmodule

// File: rtl/gpio_mul_unit.sv
// gpio_mul_unit: bus-mapped multiply + popcount coprocessor.
// Ports: clk/n_reset; bus saddress,srd,swr,sdata_in,sdata_out;
// gpio_in+gpio_latch -> gpio_in_s_insp; gpio_out = completed-op count.
module gpio_mul_unit
   import gpio_mul_pkg::*;
#(
   parameter int DATA_W = 24,
   parameter int RES_W  = 32,
   parameter int CNT_W  = 16
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic [15:0] saddress,
   input  logic        srd,
   input  logic        swr,
   input  logic [31:0] sdata_in,
   output logic [31:0] sdata_out,
   input  logic [31:0] gpio_in,
   input  logic        gpio_latch,
   output logic [31:0] gpio_in_s_insp,
   output logic [31:0] gpio_out
);

   localparam int PW = 2 * DATA_W;
   localparam int LW = $clog2(RES_W + 1);

   state_e            state_q, state_d;
   logic [1:0]        b_q, b_d;
   logic [DATA_W-1:0] a1_q, a1_d, a2_q, a2_d;
   logic [RES_W-1:0]  w_q, w_d;
   logic [LW-1:0]     l_q, l_d, pop_q, pop_d, idx_q, idx_d;
   logic [CNT_W-1:0]  ops_q, ops_d;
   logic [31:0]       sdo_q, sdo_d, insp_q, insp_d;
   logic              srd_q, srd_d, srd_p_q, srd_p_d;
   logic              swr_q, swr_d, swr_p_q, swr_p_d;
   logic              lat_q, lat_d, lat_p_q, lat_p_d;

   logic              rd_acc, wr_acc, lat_acc, busy;
   logic              mul_start, mul_busy, mul_done;
   logic [PW-1:0]     prod;
   logic [RES_W-1:0]  res, res_sh;
   logic              ovf, cur_bit;
   logic              unused_sdata;

   assign rd_acc  = srd_q & ~srd_p_q;
   assign wr_acc  = swr_q & ~swr_p_q;
   assign lat_acc = lat_q & ~lat_p_q;
   assign busy    = (state_q != IDLE);

   // Popcount walks the held product; upper bits only feed overflow.
   assign res     = prod[RES_W-1:0];
   assign res_sh  = res >> idx_q;
   assign cur_bit = res_sh[0];
   assign ovf     = |(prod >> RES_W);

   assign unused_sdata = ^sdata_in;

   assign sdata_out      = sdo_q;
   assign gpio_in_s_insp = insp_q;
   assign gpio_out       = 32'(ops_q);

   mul_shift_add #(
      .DATA_W(DATA_W)
   ) u_mul (
      .clk    (clk),
      .n_reset(n_reset),
      .start  (mul_start),
      .a      (a1_q),
      .b      (a2_q),
      .busy   (mul_busy),
      .done   (mul_done),
      .prod   (prod)
   );

   always_comb begin
      state_d   = state_q;
      b_d       = b_q;
      a1_d      = a1_q;
      a2_d      = a2_q;
      w_d       = w_q;
      l_d       = l_q;
      pop_d     = pop_q;
      idx_d     = idx_q;
      ops_d     = ops_q;
      sdo_d     = sdo_q;
      insp_d    = insp_q;
      srd_d     = srd;
      srd_p_d   = srd_q;
      swr_d     = swr;
      swr_p_d   = swr_q;
      lat_d     = gpio_latch;
      lat_p_d   = lat_q;
      mul_start = 1'b0;

      if (lat_acc) insp_d = gpio_in;

      // Visible W/L only change in DONE, so busy reads see the last result.
      if (rd_acc) begin
         unique case (1'b1)
            saddress == ADDR_A1:   sdo_d = 32'(a1_q);
            saddress == ADDR_A2:   sdo_d = 32'(a2_q);
            saddress == ADDR_W:    sdo_d = 32'(w_q);
            saddress == ADDR_L:    sdo_d = 32'(l_q);
            saddress == ADDR_CTRL: sdo_d = {30'b0, b_q};
            default:               sdo_d = '0;
         endcase
      end

      if (wr_acc && !busy) begin
         if (saddress == ADDR_A1) a1_d = sdata_in[DATA_W-1:0];
         if (saddress == ADDR_A2) a2_d = sdata_in[DATA_W-1:0];
      end

      unique case (state_q)
         IDLE: begin
            if (wr_acc && saddress == ADDR_CTRL) begin
               mul_start = 1'b1;
               b_d       = ST_BUSY;
               state_d   = MUL;
            end
         end
         MUL: begin
            if (mul_busy && mul_done) begin
               idx_d   = '0;
               pop_d   = '0;
               state_d = CNT;
            end
         end
         CNT: begin
            pop_d = pop_q + LW'(cur_bit);
            if (idx_q == LW'(RES_W - 1)) state_d = DONE;
            else idx_d = idx_q + LW'(1);
         end
         DONE: begin
            w_d     = res;
            l_d     = pop_q;
            b_d     = ovf ? ST_OVF : ST_OK;
            ops_d   = ops_q + CNT_W'(1);
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= IDLE;
         b_q     <= ST_IDLE;
         a1_q    <= '0;
         a2_q    <= '0;
         w_q     <= '0;
         l_q     <= '0;
         pop_q   <= '0;
         idx_q   <= '0;
         ops_q   <= '0;
         sdo_q   <= '0;
         insp_q  <= '0;
         srd_q   <= 1'b0;
         srd_p_q <= 1'b0;
         swr_q   <= 1'b0;
         swr_p_q <= 1'b0;
         lat_q   <= 1'b0;
         lat_p_q <= 1'b0;
      end else begin
         state_q <= state_d;
         b_q     <= b_d;
         a1_q    <= a1_d;
         a2_q    <= a2_d;
         w_q     <= w_d;
         l_q     <= l_d;
         pop_q   <= pop_d;
         idx_q   <= idx_d;
         ops_q   <= ops_d;
         sdo_q   <= sdo_d;
         insp_q  <= insp_d;
         srd_q   <= srd_d;
         srd_p_q <= srd_p_d;
         swr_q   <= swr_d;
         swr_p_q <= swr_p_d;
         lat_q   <= lat_d;
         lat_p_q <= lat_p_d;
      end
   end

endmodule
